servo_controller_multi: RTL

- Parametrised N-channel successor to the single-channel servo controller, driving NUM_CH hobby servos from one 100 MHz clock.
- Each channel has a commanded target angle (0..ANGLE_MAX) and a ramp speed. The pulse width slews toward the target at a fixed ramp rate.
- Runs entirely on clock enables: no derived clocks. A shared PWM frame keeps all channel outputs phase-aligned.
- Adds features the single-channel block lacks: glitch-free frame-boundary updates, per-channel at-target status, and input clamping with an error flag.

---
 rtl/servo_controller_multi_if.sv | 11 +
 rtl/servo_controller_multi.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/servo_controller_multi_if.sv
// Command port bundle for servo_controller_multi: write strobe, channel/angle/speed, error pulse.
interface servo_controller_multi_if;
  logic       cmd_valid;
  logic [3:0] cmd_ch;
  logic [7:0] cmd_angle;
  logic [3:0] cmd_speed;
  logic       cmd_err;

  modport master (output cmd_valid, cmd_ch, cmd_angle, cmd_speed, input cmd_err);
  modport slave  (input cmd_valid, cmd_ch, cmd_angle, cmd_speed, output cmd_err);
endinterface

// File: rtl/servo_controller_multi.sv
// N-channel hobby-servo PWM controller with ramped pulse widths and a shared,
// phase-aligned frame; widths and enables are latched only at frame boundaries.
module servo_controller_multi #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned TICK_DIV     = 1000,
  parameter int unsigned RAMP_DIV     = 5000000,
  parameter int unsigned PERIOD_TICKS = 2000,
  parameter int unsigned MIN_PW       = 70,
  parameter int unsigned MAX_PW       = 230,
  parameter int unsigned INIT_PW      = 150,
  parameter int unsigned ANGLE_MAX    = 180,
  parameter int unsigned SPEED_MAX    = 10,
  parameter int unsigned PW_W         = 12
) (
  input  logic                      clk_100M,
  input  logic                      rst_n,
  servo_controller_multi_if.slave   cmd_if,
  input  logic [NUM_CH-1:0]         ch_en,
  output logic [NUM_CH-1:0]         pwm_out,
  output logic [NUM_CH-1:0]         at_target,
  output logic                      frame_start
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RampW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PW_W-1:0] InitPw = PW_W'(INIT_PW);

  logic [TickW-1:0] r_tick_cnt;
  logic [RampW-1:0] r_ramp_cnt;
  logic [PW_W-1:0]  r_frame_cnt;
  logic             r_frame_start;
  logic             r_cmd_err;

  logic [PW_W-1:0]  r_target [NUM_CH];
  logic [PW_W-1:0]  r_pw     [NUM_CH];
  logic [PW_W-1:0]  r_pw_lat [NUM_CH];
  logic [3:0]       r_speed  [NUM_CH];
  logic [NUM_CH-1:0] r_en_lat;
  logic [NUM_CH-1:0] r_pwm;
  logic [NUM_CH-1:0] r_at_target;

  logic w_pwm_tick;
  logic w_ramp_tick;
  logic w_frame_wrap;

  assign w_pwm_tick   = (r_tick_cnt == TickW'(TICK_DIV - 1));
  assign w_ramp_tick  = (r_ramp_cnt == RampW'(RAMP_DIV - 1));
  assign w_frame_wrap = w_pwm_tick && (r_frame_cnt == PW_W'(PERIOD_TICKS - 1));

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt    <= '0;
      r_ramp_cnt    <= '0;
      r_frame_cnt   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_tick_cnt    <= w_pwm_tick ? '0 : r_tick_cnt + 1'b1;
      r_ramp_cnt    <= w_ramp_tick ? '0 : r_ramp_cnt + 1'b1;
      r_frame_start <= w_frame_wrap;
      if (w_pwm_tick) begin
        r_frame_cnt <= w_frame_wrap ? '0 : r_frame_cnt + 1'b1;
      end
    end
  end

  // Command decode: clamp out-of-range fields and map angle to a pulse width.
  logic            w_ch_ok;
  logic            w_angle_bad;
  logic            w_speed_bad;
  logic [7:0]      w_angle;
  logic [3:0]      w_speed;
  logic [PW_W-1:0] w_cmd_tgt;

  always_comb begin
    w_ch_ok     = 32'(cmd_if.cmd_ch) < NUM_CH;
    w_angle_bad = 32'(cmd_if.cmd_angle) > ANGLE_MAX;
    w_speed_bad = 32'(cmd_if.cmd_speed) > SPEED_MAX;
    w_angle     = w_angle_bad ? 8'(ANGLE_MAX) : cmd_if.cmd_angle;
    w_speed     = w_speed_bad ? 4'(SPEED_MAX) : cmd_if.cmd_speed;
    w_cmd_tgt   = PW_W'(MIN_PW + (32'(w_angle) * (MAX_PW - MIN_PW)) / ANGLE_MAX);
  end

  // Ramp step on a signed difference so the snap-to-target test sees the true distance.
  logic signed [PW_W:0] w_diff   [NUM_CH];
  logic        [PW_W:0] w_mag    [NUM_CH];
  logic [PW_W-1:0]      w_pw_nxt [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_diff[i]   = $signed({1'b0, r_target[i]}) - $signed({1'b0, r_pw[i]});
      w_mag[i]    = w_diff[i][PW_W] ? (PW_W + 1)'(-w_diff[i]) : w_diff[i];
      w_pw_nxt[i] = r_pw[i];
      if (r_speed[i] != 4'd0) begin
        if (w_mag[i] <= (PW_W + 1)'(r_speed[i])) begin
          w_pw_nxt[i] = r_target[i];
        end else if (!w_diff[i][PW_W]) begin
          w_pw_nxt[i] = r_pw[i] + PW_W'(r_speed[i]);
        end else begin
          w_pw_nxt[i] = r_pw[i] - PW_W'(r_speed[i]);
        end
      end
    end
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_target[i] <= InitPw;
        r_pw[i]     <= InitPw;
        r_pw_lat[i] <= InitPw;
        r_speed[i]  <= 4'd0;
      end
      r_en_lat    <= '0;
      r_pwm       <= '0;
      r_at_target <= '1;
      r_cmd_err   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_ramp_tick) begin
          r_pw[i] <= w_pw_nxt[i];
        end
        if (w_frame_wrap) begin
          r_pw_lat[i] <= r_pw[i];
        end
        if (cmd_if.cmd_valid && (cmd_if.cmd_ch == 4'(i))) begin
          r_target[i] <= w_cmd_tgt;
          r_speed[i]  <= w_speed;
        end
        r_at_target[i] <= (r_pw[i] == r_target[i]);
        r_pwm[i]       <= r_en_lat[i] && (r_frame_cnt < r_pw_lat[i]);
      end
      if (w_frame_wrap) begin
        r_en_lat <= ch_en;
      end
      r_cmd_err <= cmd_if.cmd_valid && (!w_ch_ok || w_angle_bad || w_speed_bad);
    end
  end

  assign pwm_out        = r_pwm;
  assign at_target      = r_at_target;
  assign frame_start    = r_frame_start;
  assign cmd_if.cmd_err = r_cmd_err;

endmodule
